// File: rtl/relu_maxpool_2x2.sv
// Bias + ReLU + requantise to u8, then 2x2 stride-2 max pooling with a half-width line buffer.
// Optional feature: define MAXPOOL_BYPASS_EN to add the pool_bypass input (per-sample pooling bypass).
module relu_maxpool_2x2 #(
    parameter int MAX_WIDTH = 1280,
    parameter int CONV_W    = 20,
    parameter int BIAS_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     conv_valid,
    input  logic signed [CONV_W-1:0] conv_in,
    input  logic        [10:0]       x_in,
    input  logic        [9:0]        y_in,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic        [3:0]        shift,
    output logic        [7:0]        pool_out,
    output logic                     pool_valid,
    output logic        [10:0]       x_out,
    output logic        [9:0]        y_out,
    output logic                     seq_err
`ifdef MAXPOOL_BYPASS_EN
    ,
    input  logic                     pool_bypass
`endif
);

    localparam int         LB_DEPTH = MAX_WIDTH / 2;
    localparam int         C_W      = $clog2(LB_DEPTH);
    localparam int         S_W      = CONV_W + 1;
    localparam logic [10:0] X_LIM   = 11'(MAX_WIDTH);

    function automatic logic [7:0] f_quant(
        input logic signed [CONV_W-1:0] c,
        input logic signed [BIAS_W-1:0] b,
        input logic        [3:0]        sh
    );
        logic [S_W-1:0] s;
        logic [S_W-1:0] r;
        logic [S_W-1:0] q;
        s = {c[CONV_W-1], c} + {{(S_W-BIAS_W){b[BIAS_W-1]}}, b};
        r = s[S_W-1] ? {S_W{1'b0}} : s;
        q = r >> sh;
        return (|q[S_W-1:8]) ? 8'hFF : q[7:0];
    endfunction

    function automatic logic [7:0] f_max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Stage 1 registers
    logic         r_s1_valid;
    logic [7:0]   r_s1_q8;
    logic [10:0]  r_s1_x;
    logic [9:0]   r_s1_y;
    logic         w_s1_byp;
    logic         w_x_oob;

    // Horizontal pairing state and stage 2 registers
    logic         r_pend;
    logic [C_W-1:0] r_pend_c;
    logic [7:0]   r_h;
    logic         r_s2_valid;
    logic [7:0]   r_s2_m;
    logic [C_W-1:0] r_s2_c;
    logic [9:0]   r_s2_y;

    logic         w_s1_pool;
    logic         w_pend_nxt;
    logic [C_W-1:0] w_pend_c_nxt;
    logic [7:0]   w_h_nxt;
    logic         w_pair;
    logic         w_pair_err;
    logic [7:0]   w_m;

    // Line buffer: one {max, row-pair tag} entry per output column
    logic [LB_DEPTH-1:0] r_lb_vld;
    logic [7:0]          r_lb_val [LB_DEPTH];
    logic [8:0]          r_lb_tag [LB_DEPTH];

    logic [8:0]   w_tag;
    logic         w_lb_wr;
    logic         w_hit;
    logic         w_miss;
    logic [7:0]   w_pool_max;
    logic         w_byp_fire;
    logic         w_byp_drop;

    logic [7:0]   r_pool_out;
    logic         r_pool_valid;
    logic [10:0]  r_x_out;
    logic [9:0]   r_y_out;
    logic         r_seq_err;

    assign w_x_oob = (x_in >= X_LIM);

`ifdef MAXPOOL_BYPASS_EN
    logic r_s1_byp;

    // Stage 1 bypass flag travels with the sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_byp <= 1'b0;
        end else if (conv_valid) begin
            r_s1_byp <= pool_bypass;
        end else begin
            r_s1_byp <= r_s1_byp;
        end
    end

    assign w_s1_byp = r_s1_byp;
`else
    assign w_s1_byp = 1'b0;
`endif

    // Stage 1: bias, ReLU, shift and saturate to u8
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_q8    <= 8'd0;
            r_s1_x     <= 11'd0;
            r_s1_y     <= 10'd0;
        end else begin
            r_s1_valid <= conv_valid & ~w_x_oob;
            if (conv_valid) begin
                r_s1_q8 <= f_quant(conv_in, bias, shift);
                r_s1_x  <= x_in;
                r_s1_y  <= y_in;
            end
        end
    end

    assign w_s1_pool = r_s1_valid & ~w_s1_byp;

    // Stage 2: pair even/odd columns of the same row
    always_comb begin
        w_pend_nxt   = r_pend;
        w_pend_c_nxt = r_pend_c;
        w_h_nxt      = r_h;
        w_pair       = 1'b0;
        w_pair_err   = 1'b0;
        w_m          = f_max8(r_h, r_s1_q8);
        if (w_s1_pool) begin
            if (!r_s1_x[0]) begin
                w_pend_nxt   = 1'b1;
                w_pend_c_nxt = r_s1_x[C_W:1];
                w_h_nxt      = r_s1_q8;
            end else if (r_pend && (r_pend_c == r_s1_x[C_W:1])) begin
                w_pend_nxt = 1'b0;
                w_pair     = 1'b1;
            end else begin
                w_pend_nxt = 1'b0;
                w_pair_err = 1'b1;
            end
        end else begin
            w_pend_nxt = r_pend;
        end
    end

    // Stage 2 registers and pending-pair state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend     <= 1'b0;
            r_pend_c   <= {C_W{1'b0}};
            r_h        <= 8'd0;
            r_s2_valid <= 1'b0;
            r_s2_m     <= 8'd0;
            r_s2_c     <= {C_W{1'b0}};
            r_s2_y     <= 10'd0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_c   <= w_pend_c_nxt;
            r_h        <= w_h_nxt;
            r_s2_valid <= w_pair;
            if (w_pair) begin
                r_s2_m <= w_m;
                r_s2_c <= r_s1_x[C_W:1];
                r_s2_y <= r_s1_y;
            end
        end
    end

    // Stage 3: even rows store, odd rows compare against the stored row-pair tag
    always_comb begin
        w_tag      = r_s2_y[9:1];
        w_lb_wr    = 1'b0;
        w_hit      = 1'b0;
        w_miss     = 1'b0;
        w_pool_max = f_max8(r_lb_val[r_s2_c], r_s2_m);
        if (r_s2_valid) begin
            if (!r_s2_y[0]) begin
                w_lb_wr = 1'b1;
            end else if (r_lb_vld[r_s2_c] && (r_lb_tag[r_s2_c] == w_tag)) begin
                w_hit = 1'b1;
            end else begin
                w_miss = 1'b1;
            end
        end else begin
            w_lb_wr = 1'b0;
        end
    end

    // Entry valid bits need reset so a new frame never reads stale data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lb_vld <= {LB_DEPTH{1'b0}};
        end else if (w_lb_wr) begin
            r_lb_vld[r_s2_c] <= 1'b1;
        end else begin
            r_lb_vld <= r_lb_vld;
        end
    end

    // Line buffer payload; guarded by r_lb_vld so no reset is needed
    always_ff @(posedge clk) begin
        if (w_lb_wr) begin
            r_lb_val[r_s2_c] <= r_s2_m;
            r_lb_tag[r_s2_c] <= w_tag;
        end
    end

    // A pooled result owns the output slot; a colliding bypass sample is flagged
    assign w_byp_fire = r_s1_valid & w_s1_byp & ~w_hit;
    assign w_byp_drop = r_s1_valid & w_s1_byp & w_hit;

    // Output registers and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pool_out   <= 8'd0;
            r_pool_valid <= 1'b0;
            r_x_out      <= 11'd0;
            r_y_out      <= 10'd0;
            r_seq_err    <= 1'b0;
        end else begin
            r_pool_valid <= w_hit | w_byp_fire;
            r_seq_err    <= r_seq_err | (conv_valid & w_x_oob) | w_pair_err | w_miss | w_byp_drop;
            if (w_hit) begin
                r_pool_out <= w_pool_max;
                r_x_out    <= 11'(r_s2_c);
                r_y_out    <= 10'(w_tag);
            end else if (w_byp_fire) begin
                r_pool_out <= r_s1_q8;
                r_x_out    <= r_s1_x;
                r_y_out    <= r_s1_y;
            end
        end
    end

    assign pool_out   = r_pool_out;
    assign pool_valid = r_pool_valid;
    assign x_out      = r_x_out;
    assign y_out      = r_y_out;
    assign seq_err    = r_seq_err;

endmodule
